pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Program-counter generator; the stage directly upstream of the IF stage.
//   It drives the 8-bit word address pc_out into IF's pc_in every cycle.
//   Handles sequential increment, stall hold and jr/jump/branch redirects
//   (with a one-cycle flush pulse to the downstream IF/ID register).
//   Handles a halt request that drains the pipe, then freezes the PC.
// PARAMETERS
//   RESET_PC      8'h00  word address loaded on reset
//   DRAIN_CYCLES  4      cycles spent in DRAIN before HALT (1..15)
//   PERF_W        16     width of the performance counters (PC_PERF_EN only)
// PORTS
//   clk             in   1    single clock; all state updates on posedge
//   rst             in   1    synchronous, active-high reset
//   stall           in   1    hold PC (hazard unit)
//   branch_taken    in   1    branch resolved taken this cycle
//   branch_pc       in   8    word address of the taken branch
//   branch_offset   in   16   signed word offset (bits [7:0] used)
//   jump            in   1    j/jal redirect
//   jump_index      in   26   jump index (bits [7:0] used)
//   jr              in   1    jr redirect
//   jr_target       in   32   register target, word address (bits [7:0] used)
//   halt_req        in   1    begin halt sequence
//   pc_out          out  8    current fetch address -> IF pc_in
//   pc_plus1        out  8    pc_out + 1, mod 256 (for jal link)
//   pc_valid        out  1    pc_out is a real fetch
//   flush_out       out  1    kill the wrong-path instruction in IF/ID
//   halted          out  1    PC frozen permanently until rst
//   redirect_count  out  PERF_W  redirects taken (PC_PERF_EN only)
//   stall_count     out  PERF_W  cycles held by stall (PC_PERF_EN only)
// BEHAVIOUR
//   - Reset (rst high at posedge): pc_out=RESET_PC, pc_valid=0, flush_out=0,
//     halted=0, state=RUN, drain counter=0, perf counters=0.
//     First cycle after rst falls: pc_valid=1, pc_out=RESET_PC.
//   - FSM states RUN, DRAIN, HALT; two-bit encoding.
//   - RUN next-PC priority (highest first): jr -> jr_target[7:0];
//     jump -> jump_index[7:0]; branch_taken -> branch_pc+1+branch_offset[7:0];
//     stall -> hold; else pc_out+1.
//   - A redirect overrides stall in the same cycle.
//   - All address arithmetic is 8-bit, mod 256: 8'hFF+1 wraps to 8'h00.
//     The upper bits of offset, index and target are ignored.
//   - Redirect: next pc_out=target; flush_out=1 for exactly that next cycle.
//     Back-to-back redirects each give a one-cycle flush pulse.
//   - pc_plus1 is combinational from pc_out.
//   - halt_req in RUN: takes priority over redirect and stall.
//     PC holds, pc_valid=0, flush_out=0, state->DRAIN, counter=0.
//   - DRAIN: counter increments every cycle; all redirect, stall and
//     halt_req inputs are ignored. When counter==DRAIN_CYCLES-1 -> HALT.
//   - HALT: halted=1, pc_valid=0, PC frozen. Only rst exits.
//   - rst mid-DRAIN or in HALT: full reset values, as above, next cycle.
// CONFIGURATION
//   PC_PERF_EN defined:
//     - redirect_count +1 per accepted redirect in RUN.
//     - stall_count +1 per RUN cycle held by stall with no redirect.
//     - Both counters saturate at all-ones and clear on rst.
//   PC_PERF_EN undefined:
//     - Both ports are still present, tied to 0; no counter flops.
// TESTING
//   1. Reset release, 5 idle cycles -> pc_out 00,01,02,03,04; pc_valid=1;
//      flush_out=0 throughout.
//   2. pc_out=8'hFE, no events for 3 cycles -> FE, FF, 00
//      (wrap; pc_plus1 at FF reads 00).
//   3. branch_taken, branch_pc=8'h10, offset=16'hFFFC -> next pc_out=8'h0D,
//      flush_out=1 for one cycle; redirect_count=1 (PC_PERF_EN).
//   4. jr (target 32'h40) and jump (index 8'h20) asserted together with stall
//      -> next pc_out=8'h40, flush pulse.
//      Separately, stall for 3 cycles at pc=8'h05 -> pc holds at 05,
//      stall_count=3.
//   5. halt_req at pc=8'h22 with branch_taken also asserted -> pc stays 22;
//      pc_valid=0 for 4 DRAIN cycles; then halted=1; redirects ignored.
//   6. rst pulsed on the 2nd DRAIN cycle -> pc_out=RESET_PC, halted=0,
//      state RUN, counters 0.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator feeding the IF stage (RUN/DRAIN/HALT).
// Optional perf counters are built only when PC_PERF_EN is defined.
module pc_gen #(
   parameter logic [7:0] RESET_PC     = 8'h00,
   parameter int         DRAIN_CYCLES = 4,
   parameter int         PERF_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [7:0]        branch_pc,
   input  logic [15:0]       branch_offset,
   input  logic              jump,
   input  logic [25:0]       jump_index,
   input  logic              jr,
   input  logic [31:0]       jr_target,
   input  logic              halt_req,
   output logic [7:0]        pc_out,
   output logic [7:0]        pc_plus1,
   output logic              pc_valid,
   output logic              flush_out,
   output logic              halted,
   output logic [PERF_W-1:0] redirect_count,
   output logic [PERF_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [3:0] drain_q, drain_d;
   logic       valid_q, valid_d;
   logic       flush_q, flush_d;
   logic       halted_q, halted_d;
   logic       redirect, stall_hold;
   logic [7:0] target;

   always_comb begin
      if (jr)
         target = jr_target[7:0];
      else if (jump)
         target = jump_index[7:0];
      else
         target = branch_pc + 8'd1 + branch_offset[7:0];
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drain_d    = drain_q;
      valid_d    = valid_q;
      flush_d    = 1'b0;
      halted_d   = halted_q;
      redirect   = 1'b0;
      stall_hold = 1'b0;
      case (state_q)
         RUN: begin
            // valid_q is low in RUN only on the first cycle out of reset
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (halt_req) begin
               state_d = DRAIN;
               valid_d = 1'b0;
               drain_d = 4'd0;
            end else if (jr || jump || branch_taken) begin
               pc_d     = target;
               flush_d  = 1'b1;
               redirect = 1'b1;
            end else if (stall) begin
               stall_hold = 1'b1;
            end else begin
               pc_d = pc_q + 8'd1;
            end
         end
         DRAIN: begin
            drain_d = drain_q + 4'd1;
            if (drain_q == DRAIN_LAST) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end
         end
         HALT: begin
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         drain_q  <= 4'd0;
         valid_q  <= 1'b0;
         flush_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         drain_q  <= drain_d;
         valid_q  <= valid_d;
         flush_q  <= flush_d;
         halted_q <= halted_d;
      end
   end

   assign pc_out    = pc_q;
   assign pc_plus1  = pc_q + 8'd1;
   assign pc_valid  = valid_q;
   assign flush_out = flush_q;
   assign halted    = halted_q;

`ifdef PC_PERF_EN
   logic [PERF_W-1:0] redirect_count_q, redirect_count_d;
   logic [PERF_W-1:0] stall_count_q, stall_count_d;

   always_comb begin
      redirect_count_d = redirect_count_q;
      stall_count_d    = stall_count_q;
      if (redirect && (redirect_count_q != '1))
         redirect_count_d = redirect_count_q + 1'b1;
      if (stall_hold && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_count_q <= '0;
         stall_count_q    <= '0;
      end else begin
         redirect_count_q <= redirect_count_d;
         stall_count_q    <= stall_count_d;
      end
   end

   assign redirect_count = redirect_count_q;
   assign stall_count    = stall_count_q;

   logic unused_bits;
   assign unused_bits = &{1'b0, branch_offset[15:8], jump_index[25:8], jr_target[31:8]};
`else
   assign redirect_count = '0;
   assign stall_count    = '0;

   logic unused_bits;
   assign unused_bits = &{1'b0, branch_offset[15:8], jump_index[25:8], jr_target[31:8],
                          redirect, stall_hold};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed + randomized bench for pc_gen against a behavioural model.
module tb_pc_gen;
   localparam logic [7:0] RESET_PC     = 8'h00;
   localparam int         DRAIN_CYCLES = 4;
   localparam int         PERF_W       = 16;
`ifdef PC_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, stall, branch_taken, jump, jr, halt_req;
   logic [7:0]        branch_pc;
   logic [15:0]       branch_offset;
   logic [25:0]       jump_index;
   logic [31:0]       jr_target;
   logic [7:0]        pc_out, pc_plus1;
   logic              pc_valid, flush_out, halted;
   logic [PERF_W-1:0] redirect_count, stall_count;

   int errors = 0;
   int checks = 0;

   int m_pc, m_drain, m_redir, m_stall;
   bit m_valid, m_flush, m_halted, m_fresh;

   pc_gen #(.RESET_PC(RESET_PC), .DRAIN_CYCLES(DRAIN_CYCLES), .PERF_W(PERF_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_pc(branch_pc), .branch_offset(branch_offset), .jump(jump),
      .jump_index(jump_index), .jr(jr), .jr_target(jr_target), .halt_req(halt_req),
      .pc_out(pc_out), .pc_plus1(pc_plus1), .pc_valid(pc_valid), .flush_out(flush_out),
      .halted(halted), .redirect_count(redirect_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= (1 << PERF_W) - 1) ? v : v + 1;
   endfunction

   task automatic clear_inputs();
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
      halt_req = 1'b0; branch_pc = '0; branch_offset = '0; jump_index = '0; jr_target = '0;
   endtask

   // Spec-level model: what the PC should be after one clock with the applied inputs
   task automatic model_step();
      m_flush = 1'b0;
      if (rst) begin
         m_pc = RESET_PC; m_valid = 0; m_halted = 0; m_drain = -1;
         m_redir = 0; m_stall = 0; m_fresh = 1;
      end else if (m_halted) begin
      end else if (m_drain >= 0) begin
         m_drain++;
         if (m_drain == DRAIN_CYCLES) m_halted = 1;
      end else if (m_fresh) begin
         m_fresh = 0; m_valid = 1;
      end else if (halt_req) begin
         m_valid = 0; m_drain = 0;
      end else if (jr) begin
         m_pc = jr_target % 256; m_flush = 1; m_redir = sat_inc(m_redir);
      end else if (jump) begin
         m_pc = jump_index % 256; m_flush = 1; m_redir = sat_inc(m_redir);
      end else if (branch_taken) begin
         m_pc = ((int'(branch_pc) + 1 + int'($signed(branch_offset))) % 256 + 256) % 256;
         m_flush = 1; m_redir = sat_inc(m_redir);
      end else if (stall) begin
         m_stall = sat_inc(m_stall);
      end else begin
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic check_all();
      check_eq("pc_out", pc_out, m_pc);
      check_eq("pc_plus1", pc_plus1, (m_pc + 1) % 256);
      check_eq("pc_valid", pc_valid, m_valid);
      check_eq("flush_out", flush_out, m_flush);
      check_eq("halted", halted, m_halted);
      check_eq("redirect_count", redirect_count, PERF ? m_redir : 0);
      check_eq("stall_count", stall_count, PERF ? m_stall : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      check_all();
   endtask

   initial begin
      m_pc = 0; m_drain = -1; m_redir = 0; m_stall = 0;
      m_valid = 0; m_flush = 0; m_halted = 0; m_fresh = 1;
      clear_inputs();
      rst = 1'b1;
      tick(); tick();
      check_eq("reset_valid", pc_valid, 1'b0);
      check_eq("reset_pc", pc_out, RESET_PC);

      // reset release and sequential fetch
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_eq("seq_pc4", pc_out, 8'h04);

      // wrap at FF
      jr = 1'b1; jr_target = 32'hFFFF_FFFE;
      tick();
      clear_inputs();
      tick();
      check_eq("wrap_pc_ff", pc_out, 8'hFF);
      check_eq("wrap_plus1", pc_plus1, 8'h00);
      tick();
      check_eq("wrap_pc_00", pc_out, 8'h00);

      // backward branch
      branch_taken = 1'b1; branch_pc = 8'h10; branch_offset = 16'hFFFC;
      tick();
      clear_inputs();
      check_eq("br_target", pc_out, 8'h0D);
      check_eq("br_flush", flush_out, 1'b1);
      tick();

      // jr beats jump beats stall
      jr = 1'b1; jr_target = 32'h40; jump = 1'b1; jump_index = 26'h20; stall = 1'b1;
      tick();
      clear_inputs();
      check_eq("jr_prio", pc_out, 8'h40);
      jr = 1'b1; jr_target = 32'h05;
      tick();
      clear_inputs();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      clear_inputs();
      check_eq("stall_hold", pc_out, 8'h05);

      // halt beats redirect; drain then freeze
      jump = 1'b1; jump_index = 26'h22;
      tick();
      halt_req = 1'b1; branch_taken = 1'b1; branch_pc = 8'h80;
      tick();
      check_eq("halt_pc", pc_out, 8'h22);
      check_eq("halt_valid", pc_valid, 1'b0);
      jr = 1'b1; jr_target = 32'h99;
      for (int i = 0; i < 3; i++) tick();
      check_eq("drain_not_halted", halted, 1'b0);
      tick();
      check_eq("halted_set", halted, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      check_eq("halt_frozen", pc_out, 8'h22);
      clear_inputs();

      // reset mid-drain
      rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
      halt_req = 1'b1; tick();
      clear_inputs(); tick();
      rst = 1'b1; tick();
      check_eq("rst_drain_halted", halted, 1'b0);
      check_eq("rst_drain_pc", pc_out, RESET_PC);
      rst = 1'b0; tick();
      check_eq("rst_drain_valid", pc_valid, 1'b1);

      // randomized run
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 149) == 0);
         halt_req      = ($urandom_range(0, 119) == 0);
         stall         = ($urandom_range(0, 9) < 3);
         branch_taken  = ($urandom_range(0, 9) == 0);
         jump          = ($urandom_range(0, 19) == 0);
         jr            = ($urandom_range(0, 19) == 0);
         branch_pc     = 8'($urandom);
         branch_offset = 16'($urandom);
         jump_index    = 26'($urandom);
         jr_target     = $urandom;
         tick();
      end
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
